// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..width inclusive
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_str.sv
// rtl/full_adder_str.sv - single-bit structural full adder cell
module full_adder_str (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_ab_xor;
    logic w_ab_and;
    logic w_c_and;

    xor g_xor_ab  (w_ab_xor, i_a, i_b);
    xor g_xor_sum (o_sum, w_ab_xor, i_cin);
    and g_and_ab  (w_ab_and, i_a, i_b);
    and g_and_c   (w_c_and, w_ab_xor, i_cin);
    or  g_or_cout (o_cout, w_ab_and, w_c_and);

endmodule

// File: rtl/serial_adder_param.sv
// rtl/serial_adder_param.sv - bit-serial WIDTH-bit adder with start/done handshake
module serial_adder_param
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_part_next;
    logic             w_last;

    // One shared cell processes the current LSBs and the running carry
    full_adder_str u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
    assign w_part_next = WIDTH'({w_fa_sum, r_part} >> 1);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // Control FSM, shift datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_part  <= w_part_next;
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        sum     <= w_part_next;
                        cout    <= w_fa_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
